// File: rtl/alignment_packer_pkg.sv
// Shared constants and FSM encoding for the alignment packer.
package alignment_packer_pkg;

  localparam int BP_WIDTH_DEF = 2;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

endpackage

// File: rtl/packer_fifo.sv
// Synchronous show-ahead word FIFO; the head entry and all flags are registered.
module packer_fifo #(
  parameter int DW    = 38,
  parameter int DEPTH = 8
)(
  input  logic                         clk,
  input  logic                         reset_i,
  input  logic                         push_i,
  input  logic [DW-1:0]                data_i,
  input  logic                         pop_i,
  output logic [DW-1:0]                head_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH+1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] head_q, head_d;
  logic          empty_q, full_q;
  logic          do_pop_s, do_push_s;

  // Next pointers/count; a push into a full FIFO is allowed when the head leaves on the same edge.
  always_comb begin
    do_pop_s  = pop_i && !empty_q;
    do_push_s = push_i && (!full_q || do_pop_s);
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (do_pop_s) begin
      rd_d = (rd_q == AW'(DEPTH-1)) ? {AW{1'b0}} : rd_q + AW'(1);
    end else begin
      rd_d = rd_q;
    end
    if (do_push_s) begin
      wr_d = (wr_q == AW'(DEPTH-1)) ? {AW{1'b0}} : wr_q + AW'(1);
    end else begin
      wr_d = wr_q;
    end
    if (do_push_s && !do_pop_s) begin
      cnt_d = cnt_q + NW'(1);
    end else if (!do_push_s && do_pop_s) begin
      cnt_d = cnt_q - NW'(1);
    end else begin
      cnt_d = cnt_q;
    end
    if (cnt_d == {NW{1'b0}}) begin
      head_d = {DW{1'b0}};
    end else if (do_push_s && (wr_q == rd_d)) begin
      head_d = data_i;
    end else begin
      head_d = mem_q[rd_d];
    end
  end

  // Storage, pointers and registered head/flags.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {DW{1'b0}};
      rd_q    <= {AW{1'b0}};
      wr_q    <= {AW{1'b0}};
      cnt_q   <= {NW{1'b0}};
      head_q  <= {DW{1'b0}};
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      if (do_push_s) mem_q[wr_q] <= data_i;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      empty_q <= (cnt_d == {NW{1'b0}});
      full_q  <= (cnt_d == NW'(DEPTH));
    end
  end

  assign head_o  = head_q;
  assign empty_o = empty_q;
  assign full_o  = full_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/alignment_packer.sv
// Packs traceback symbols into fixed-width words, marks the final word of each
// alignment, and buffers words for the host.
module alignment_packer
  import alignment_packer_pkg::*;
#(
  parameter int BP_WIDTH   = BP_WIDTH_DEF,
  parameter int WORD_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_WIDTH  = 16
)(
  input  logic                                          clk,
  input  logic                                          reset_i,
  input  logic [BP_WIDTH-1:0]                           alignment_in,
  input  logic                                          alignment_valid_i,
  input  logic                                          tb_done_i,
  output logic [WORD_WIDTH-1:0]                         out_word,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [$clog2(WORD_WIDTH/BP_WIDTH+1)-1:0]      out_count,
  output logic                                          out_last,
  output logic [LEN_WIDTH-1:0]                          align_len,
  output logic                                          stall_o,
  output logic                                          overflow_o
);

  localparam int SYMS = WORD_WIDTH / BP_WIDTH;
  localparam int CW   = $clog2(SYMS+1);
  localparam int IW   = (SYMS > 1) ? $clog2(SYMS) : 1;
  localparam int EW   = WORD_WIDTH + CW + 1;
  localparam int NW   = $clog2(FIFO_DEPTH+1);

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] part_q, part_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  ovf_q, ovf_d;

  logic                  push_s;
  logic [EW-1:0]         push_data_s;
  logic [WORD_WIDTH-1:0] word_s;
  logic [IW-1:0]         idx_s;
  logic [EW-1:0]         head_s;
  logic                  empty_s, full_s, pop_s, room_s;
  logic [NW-1:0]         fifo_cnt_s;

  assign out_valid = !empty_s;
  assign out_word  = head_s[WORD_WIDTH-1:0];
  assign out_count = head_s[WORD_WIDTH +: CW];
  assign out_last  = head_s[EW-1];
  assign pop_s     = out_valid && out_ready;
  assign room_s    = !full_s || pop_s;
  assign idx_s     = cnt_q[IW-1:0];

  // Packing datapath and state transitions.
  always_comb begin
    state_d     = state_q;
    part_d      = part_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    ovf_d       = ovf_q;
    push_s      = 1'b0;
    push_data_s = {EW{1'b0}};
    word_s      = part_q;
    case (state_q)
      ST_COLLECT: begin
        if (alignment_valid_i) begin
          word_s[BP_WIDTH*idx_s +: BP_WIDTH] = alignment_in;
          len_d = (&len_q) ? len_q : len_q + LEN_WIDTH'(1);
          if (cnt_q == CW'(SYMS-1)) begin
            push_s      = room_s;
            push_data_s = {1'b0, CW'(SYMS), word_s};
            ovf_d       = ovf_q | !room_s;
            part_d      = {WORD_WIDTH{1'b0}};
            cnt_d       = {CW{1'b0}};
          end else begin
            part_d = word_s;
            cnt_d  = cnt_q + CW'(1);
          end
        end else begin
          part_d = part_q;
        end
        if (tb_done_i) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_FLUSH: begin
        if (alignment_valid_i || tb_done_i) begin
          ovf_d = 1'b1;
        end else begin
          ovf_d = ovf_q;
        end
        if (room_s) begin
          push_s      = 1'b1;
          push_data_s = {1'b1, cnt_q, part_q};
          state_d     = ST_DRAIN;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_DRAIN: begin
        if (alignment_valid_i || tb_done_i) begin
          ovf_d = 1'b1;
        end else begin
          ovf_d = ovf_q;
        end
        if (pop_s && out_last) begin
          len_d   = {LEN_WIDTH{1'b0}};
          part_d  = {WORD_WIDTH{1'b0}};
          cnt_d   = {CW{1'b0}};
          state_d = ST_COLLECT;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_COLLECT;
      end
    endcase
  end

  // Packer state registers.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= ST_COLLECT;
      part_q  <= {WORD_WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      len_q   <= {LEN_WIDTH{1'b0}};
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      part_q  <= part_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  packer_fifo #(
    .DW    (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_i (reset_i),
    .push_i  (push_s),
    .data_i  (push_data_s),
    .pop_i   (pop_s),
    .head_o  (head_s),
    .empty_o (empty_s),
    .full_o  (full_s),
    .count_o (fifo_cnt_s)
  );

  assign align_len  = len_q;
  assign overflow_o = ovf_q;
  assign stall_o    = (fifo_cnt_s >= NW'(FIFO_DEPTH-2));

endmodule

// File: tb/tb_alignment_packer.sv
// Randomised and directed bench for alignment_packer against a queue-based word model.
module tb_alignment_packer;

  localparam int SYMS  = 16;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [1:0]  alignment_in;
  logic        alignment_valid_i;
  logic        tb_done_i;
  logic [31:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_count;
  logic        out_last;
  logic [15:0] align_len;
  logic        stall_o;
  logic        overflow_o;

  always #5 clk = ~clk;

  alignment_packer dut (
    .clk               (clk),
    .reset_i           (reset_i),
    .alignment_in      (alignment_in),
    .alignment_valid_i (alignment_valid_i),
    .tb_done_i         (tb_done_i),
    .out_word          (out_word),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_count         (out_count),
    .out_last          (out_last),
    .align_len         (align_len),
    .stall_o           (stall_o),
    .overflow_o        (overflow_o)
  );

  typedef struct {
    logic [31:0] w;
    int          cnt;
    bit          last;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_part_w;
  int          m_part_n;
  int          m_len;
  bit          m_ovf;
  int          m_phase;   // 0 packing, 1 waiting to emit the last word, 2 waiting for last word to leave
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_edge();
    bit   pop, room, have_push;
    ent_t item;
    ent_t head;
    if (reset_i) begin
      m_q.delete();
      m_part_w = 32'd0;
      m_part_n = 0;
      m_len    = 0;
      m_ovf    = 1'b0;
      m_phase  = 0;
      return;
    end
    pop       = (m_q.size() > 0) && out_ready;
    room      = (m_q.size() < DEPTH) || pop;
    have_push = 1'b0;
    if (m_q.size() > 0) head = m_q[0];
    if (m_phase == 0) begin
      if (alignment_valid_i) begin
        m_part_w = m_part_w | (32'(alignment_in) << (2 * m_part_n));
        m_part_n++;
        if (m_len < 65535) m_len++;
        if (m_part_n == SYMS) begin
          item.w = m_part_w; item.cnt = SYMS; item.last = 1'b0;
          if (room) have_push = 1'b1;
          else      m_ovf = 1'b1;
          m_part_w = 32'd0;
          m_part_n = 0;
        end
      end
      if (tb_done_i) m_phase = 1;
    end else if (m_phase == 1) begin
      if (alignment_valid_i || tb_done_i) m_ovf = 1'b1;
      if (room) begin
        item.w = m_part_w; item.cnt = m_part_n; item.last = 1'b1;
        have_push = 1'b1;
        m_phase   = 2;
      end
    end else begin
      if (alignment_valid_i || tb_done_i) m_ovf = 1'b1;
      if (pop && head.last) begin
        m_len    = 0;
        m_part_w = 32'd0;
        m_part_n = 0;
        m_phase  = 0;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (have_push) m_q.push_back(item);
  endtask

  task automatic compare_all();
    bit v;
    v = (m_q.size() > 0);
    check_eq("out_valid", 64'(out_valid), 64'(v));
    check_eq("out_word",  64'(out_word),  v ? 64'(m_q[0].w)    : 64'd0);
    check_eq("out_count", 64'(out_count), v ? 64'(m_q[0].cnt)  : 64'd0);
    check_eq("out_last",  64'(out_last),  v ? 64'(m_q[0].last) : 64'd0);
    check_eq("align_len", 64'(align_len), 64'(m_len));
    check_eq("overflow",  64'(overflow_o), 64'(m_ovf));
    check_eq("stall",     64'(stall_o),   64'(m_q.size() >= DEPTH - 2));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    alignment_valid_i = 1'b0;
    tb_done_i         = 1'b0;
    repeat (n) step();
  endtask

  task automatic send_syms(input int n, input bit done_on_last);
    for (int k = 0; k < n; k++) begin
      alignment_valid_i = 1'b1;
      alignment_in      = 2'($urandom_range(0, 3));
      tb_done_i         = done_on_last && (k == n - 1);
      step();
    end
    alignment_valid_i = 1'b0;
    tb_done_i         = 1'b0;
  endtask

  task automatic pulse_done();
    alignment_valid_i = 1'b0;
    tb_done_i         = 1'b1;
    step();
    tb_done_i         = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset_i = 1'b1;
    idle(n);
    reset_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; alignment_in = 2'd0; alignment_valid_i = 1'b0;
    tb_done_i = 1'b0; out_ready = 1'b0;
    m_part_w = 32'd0; m_part_n = 0; m_len = 0; m_ovf = 1'b0; m_phase = 0;
    do_reset(2);

    // 40 counting symbols then done, host always ready
    out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      alignment_valid_i = 1'b1;
      alignment_in      = 2'(k % 4);
      step();
    end
    pulse_done();
    idle(10);

    // done on the 16th symbol: full word then empty last word
    send_syms(16, 1'b1);
    idle(8);

    // host stalled: FIFO fills, later words dropped, extra traffic while flushing
    out_ready = 1'b0;
    send_syms(160, 1'b0);
    pulse_done();
    idle(3);
    send_syms(4, 1'b0);
    pulse_done();
    out_ready = 1'b1;
    idle(20);

    // symbols arriving during drain with host stalled
    do_reset(1);
    out_ready = 1'b0;
    send_syms(3, 1'b0);
    pulse_done();
    idle(2);
    send_syms(3, 1'b0);
    idle(2);
    out_ready = 1'b1;
    idle(5);

    // reset mid-alignment, then a short alignment
    send_syms(5, 1'b0);
    do_reset(1);
    send_syms(3, 1'b0);
    pulse_done();
    idle(6);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      reset_i           = ($urandom_range(0, 999) < 2);
      alignment_valid_i = ($urandom_range(0, 99) < 70);
      alignment_in      = 2'($urandom_range(0, 3));
      tb_done_i         = ($urandom_range(0, 99) < 3);
      out_ready         = ($urandom_range(0, 99) < 60);
      step();
    end
    reset_i = 1'b0;
    out_ready = 1'b1;
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alignment_packer.md
ALIGNMENT_PACKER -- requirements
Module: alignment_packer

Interface
REQ-001 Parameter BP_WIDTH, default `BP_WIDTH (2), width of one alignment symbol.
REQ-002 Parameter WORD_WIDTH, default 32, width of a packed output word; SYMS = WORD_WIDTH/BP_WIDTH (16).
REQ-003 Parameter FIFO_DEPTH, default 8, number of output words buffered.
REQ-004 Parameter LEN_WIDTH, default 16, width of the alignment length counter.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 reset_i  input  1  reset; synchronous and active-high.
REQ-007 alignment_in  input  BP_WIDTH  traceback symbol, valid when alignment_valid_i=1.
REQ-008 alignment_valid_i  input  1  one symbol per cycle when high; no ready path back to traceback.
REQ-009 tb_done_i  input  1  one-cycle pulse marking end of the current alignment.
REQ-010 out_word  output  WORD_WIDTH  packed word at FIFO head.
REQ-011 out_valid  output  1  out_word, out_count and out_last are valid.
REQ-012 out_ready  input  1  host accepts the head word when out_valid=out_ready=1.
REQ-013 out_count  output  $clog2(SYMS+1)  valid symbols in out_word (0..SYMS).
REQ-014 out_last  output  1  head word is the final word of the alignment.
REQ-015 align_len  output  LEN_WIDTH  symbols accepted for the current alignment.
REQ-016 stall_o  output  1  high when FIFO occupancy >= FIFO_DEPTH-2 (host hint to pause traceback).
REQ-017 overflow_o  output  1  sticky: a symbol or word was lost.

Function
REQ-018 Symbol k of a word (k = 0 first received) SHALL occupy bits [BP_WIDTH*k+BP_WIDTH-1 : BP_WIDTH*k]; unused upper bits SHALL be zero.
REQ-019 FSM states: COLLECT, FLUSH, DRAIN; reset state COLLECT.
REQ-020 COLLECT: each valid symbol is appended to the partial word and align_len increments, saturating at 2^LEN_WIDTH-1.
REQ-021 When the SYMS-th symbol is appended, the full word (count SYMS, last 0) SHALL be pushed on the same edge; out_valid rises the next cycle if the FIFO was empty (1-cycle latency).
REQ-022 If the FIFO is full at push time, the word SHALL be dropped, overflow_o set, and packing continues.
REQ-023 tb_done_i in COLLECT: a symbol valid in the same cycle is included first; then go to FLUSH.
REQ-024 FLUSH: when the FIFO is not full, push the partial word with out_count = partial count (0 allowed) and out_last=1, then go to DRAIN; if the done-cycle symbol completed a word, that full word is pushed first and the final word is then an empty last word (count 0).
REQ-025 DRAIN: when the last word is popped, clear align_len and the partial word and return to COLLECT.
REQ-026 Symbols or tb_done_i arriving in FLUSH or DRAIN SHALL be discarded and set overflow_o.
REQ-027 Pop occurs on out_valid & out_ready; simultaneous push and pop on a full FIFO SHALL succeed.
REQ-028 out_word, out_count, out_last SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-029 reset_i SHALL, at any state including mid-alignment, empty the FIFO, clear partial word, align_len, overflow_o, and force COLLECT.
REQ-030 Output values during and after reset: out_valid=0, out_word=0, out_count=0, out_last=0, stall_o=0, align_len=0, overflow_o=0.

Structure
REQ-031 BP_WIDTH and the FSM state encodings SHALL live in the shared define.v; WORD_WIDTH, FIFO_DEPTH, LEN_WIDTH are module parameters.
REQ-032 The word buffer SHALL be a sub-module packer_fifo (synchronous, show-ahead, registered head, full/empty/count outputs).

Verification
REQ-033 40 symbols 0,1,2,3,... with out_ready=1, then done -> two words count 16 last 0, third word count 8 last 1, align_len 40 until pop of last word, then 0.
REQ-034 16 symbols with done asserted on the 16th cycle -> one word count 16 last 0, then one word count 0 last 1.
REQ-035 out_ready=0 and 160 symbols -> 8 words buffered, stall_o high at occupancy 6, 9th and 10th words dropped, overflow_o=1, FIFO content unchanged.
REQ-036 Symbols during DRAIN with out_ready=0 -> discarded, overflow_o=1, align_len unchanged.
REQ-037 reset_i mid-alignment after 5 symbols -> next cycle all outputs at reset values; new 3-symbol alignment then yields a single word count 3 last 1.
